// File: rtl/controller_uart1_ctrl_pkg.sv
// Shared definitions for the UART1 control port: register addresses,
// STATUS bit positions, FSM state type and the STATUS word packer.
package controller_uart1_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_TIMEOUT_BIT = 1;
  localparam int unsigned STATUS_CLRDONE_BIT = 2;
  localparam int unsigned STATUS_DONE_LSB    = 8;
  localparam int unsigned DONE_CNT_W         = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [31:0] packStatus(input logic busy, input logic timeout,
                                             input logic [DONE_CNT_W-1:0] doneCnt);
    logic [31:0] word;
    word = '0;
    word[STATUS_BUSY_BIT] = busy;
    word[STATUS_TIMEOUT_BIT] = timeout;
    word[STATUS_DONE_LSB +: DONE_CNT_W] = doneCnt;
    return word;
  endfunction

endpackage

// File: rtl/controller_uart1_control_port_if.sv
// Avalon-MM slave signals plus the valid/ready command channel to the UART core.
interface controller_uart1_control_port_if #(
  parameter int unsigned DATA_WIDTH = 10
);
  logic                  chipselect;
  logic [1:0]            address;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  waitrequest;
  logic                  cmd_valid;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_ready;

  modport slave (
    input  chipselect, address, write_n, writedata, cmd_ready,
    output readdata, waitrequest, cmd_valid, cmd_data
  );

  modport master (
    output chipselect, address, write_n, writedata, cmd_ready,
    input  readdata, waitrequest, cmd_valid, cmd_data
  );
endinterface

// File: rtl/controller_uart1_cmd_timer.sv
// Counts consecutive BUSY cycles and flags the cycle in which the command
// has been outstanding for TIMEOUT_CYCLES cycles.
module controller_uart1_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (busy_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire_o = busy_i && (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/controller_uart1_control_port.sv
// UART1 control port: Avalon-MM control register that issues each written word
// as a command to the UART core. Optional timeout via UART1_CTRL_TIMEOUT_EN.
module controller_uart1_control_port
  import controller_uart1_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 10,
  parameter int unsigned RESET_VALUE    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  controller_uart1_control_port_if.slave bus,
  output logic [DATA_WIDTH-1:0]         out_port
);

  localparam int unsigned W = DATA_WIDTH;

  state_t                state_q, state_d;
  logic [W-1:0]          ctrlReg_q, ctrlReg_d;
  logic [W-1:0]          cmdData_q, cmdData_d;
  logic                  cmdValid_q, cmdValid_d;
  logic                  timeout_q, timeout_d;
  logic [DONE_CNT_W-1:0] doneCnt_q, doneCnt_d;
  logic [31:0]           readData_q, readData_d;

  logic         busy;
  logic         writeReq;
  logic         writeEn;
  logic         statusWrite;
  logic         cmdAccept;
  logic         timerExpire;
  logic [W-1:0] wrWord;
  logic [W-1:0] ctrlNew;

  assign busy            = (state_q == BUSY);
  assign writeReq        = bus.chipselect & ~bus.write_n;
  assign bus.waitrequest = writeReq & busy & (bus.address != ADDR_STATUS);
  assign writeEn         = writeReq & ~bus.waitrequest;
  assign statusWrite     = writeEn & (bus.address == ADDR_STATUS);
  assign cmdAccept       = cmdValid_q & bus.cmd_ready;
  assign wrWord          = bus.writedata[W-1:0];

`ifdef UART1_CTRL_TIMEOUT_EN
  controller_uart1_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimer (
    .clk     (clk),
    .reset   (reset),
    .busy_i  (busy),
    .expire_o(timerExpire)
  );
`else
  assign timerExpire = 1'b0;
`endif

  always_comb begin
    ctrlNew = ctrlReg_q;
    case (bus.address)
      ADDR_DATA:     ctrlNew = wrWord;
      ADDR_OUTSET:   ctrlNew = ctrlReg_q | wrWord;
      ADDR_OUTCLEAR: ctrlNew = ctrlReg_q & ~wrWord;
      default:       ctrlNew = ctrlReg_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ctrlReg_d  = ctrlReg_q;
    cmdData_d  = cmdData_q;
    cmdValid_d = cmdValid_q;
    doneCnt_d  = doneCnt_q;
    timeout_d  = timeout_q;
    // Clear comes first so a timeout firing in the same cycle still sets the flag.
    if (statusWrite && bus.writedata[STATUS_TIMEOUT_BIT]) timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (writeEn && (bus.address != ADDR_STATUS)) begin
          ctrlReg_d  = ctrlNew;
          cmdData_d  = ctrlNew;
          cmdValid_d = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cmdAccept) begin
          cmdValid_d = 1'b0;
          doneCnt_d  = doneCnt_q + 1'b1;
          state_d    = IDLE;
        end else if (timerExpire) begin
          cmdValid_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (statusWrite && bus.writedata[STATUS_CLRDONE_BIT]) doneCnt_d = '0;
  end

  always_comb begin
    readData_d = '0;
    case (bus.address)
      ADDR_DATA:   readData_d = 32'(ctrlReg_q);
      ADDR_STATUS: readData_d = packStatus(busy, timeout_q, doneCnt_q);
      default:     readData_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrlReg_q  <= W'(RESET_VALUE);
      cmdData_q  <= '0;
      cmdValid_q <= 1'b0;
      timeout_q  <= 1'b0;
      doneCnt_q  <= '0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrlReg_q  <= ctrlReg_d;
      cmdData_q  <= cmdData_d;
      cmdValid_q <= cmdValid_d;
      timeout_q  <= timeout_d;
      doneCnt_q  <= doneCnt_d;
      readData_q <= readData_d;
    end
  end

  assign out_port     = ctrlReg_q;
  assign bus.cmd_data = cmdData_q;
  assign bus.cmd_valid = cmdValid_q;
  assign bus.readdata = readData_q;

endmodule

// File: tb/tb_controller_uart1_control_port.sv
// Self-checking bench for the UART1 control port: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_controller_uart1_control_port;

  localparam int W  = 10;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] outPort;
  int           nCompared = 0;
  int           nMismatched = 0;

  logic [W-1:0] mCtrl = '0;
  logic [W-1:0] mCmd = '0;
  logic         mBusy = 1'b0;
  logic         mTimeout = 1'b0;
  logic [7:0]   mDone = '0;
  logic [31:0]  mRead = '0;
  int           mBusyCycles = 0;
  logic         sampWaitDut;
  logic         sampWaitExp;

  always #5 clk = ~clk;

  controller_uart1_control_port_if #(.DATA_WIDTH(W)) bus ();

  controller_uart1_control_port #(
    .DATA_WIDTH(W),
    .RESET_VALUE(0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .out_port(outPort)
  );

  task automatic drive(input logic cs, input logic [1:0] addr, input logic wn,
                       input logic [31:0] wd, input logic rdy);
    bus.chipselect = cs;
    bus.address    = addr;
    bus.write_n    = wn;
    bus.writedata  = wd;
    bus.cmd_ready  = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'd0, 1'b1, 32'h0, rdy);
  endtask

  // Advances one clock; the model computes what the register map should hold afterwards.
  task automatic clockCycle();
    logic         wr, stall, accept, expire;
    logic [W-1:0] wd, nCtrl, nCmd;
    logic         nBusy, nTimeout;
    logic [7:0]   nDone;
    logic [31:0]  nRead;
    int           nCycles;
    #1;
    wd = bus.writedata[W-1:0];
    wr = bus.chipselect && !bus.write_n;
    stall = wr && mBusy && (bus.address != 2'd1);
    sampWaitExp = stall;
    sampWaitDut = bus.waitrequest;
    case (bus.address)
      2'd0:    nRead = 32'(mCtrl);
      2'd1:    nRead = {16'h0, mDone, 6'h0, mTimeout, mBusy};
      default: nRead = 32'h0;
    endcase
    nCtrl = mCtrl; nCmd = mCmd; nBusy = mBusy; nTimeout = mTimeout; nDone = mDone;
    nCycles = mBusyCycles;
    accept = mBusy && bus.cmd_ready;
    expire = 1'b0;
`ifdef UART1_CTRL_TIMEOUT_EN
    expire = mBusy && !accept && (mBusyCycles == TO - 1);
`endif
    if (accept) begin
      nBusy = 1'b0;
      nDone = mDone + 8'd1;
    end else if (expire) begin
      nBusy = 1'b0;
      nTimeout = 1'b1;
    end else if (mBusy) begin
      nCycles = mBusyCycles + 1;
    end
    if (wr && !stall) begin
      case (bus.address)
        2'd0:    nCtrl = wd;
        2'd2:    nCtrl = mCtrl | wd;
        2'd3:    nCtrl = mCtrl & ~wd;
        default: nCtrl = mCtrl;
      endcase
      if (bus.address != 2'd1) begin
        nCmd = nCtrl;
        nBusy = 1'b1;
        nCycles = 0;
      end else begin
        if (bus.writedata[2]) nDone = 8'd0;
`ifdef UART1_CTRL_TIMEOUT_EN
        if (bus.writedata[1] && !expire) nTimeout = 1'b0;
`endif
      end
    end
    if (reset) begin
      nCtrl = '0; nCmd = '0; nBusy = 1'b0; nTimeout = 1'b0; nDone = '0; nRead = '0; nCycles = 0;
    end
    @(posedge clk);
    #1;
    mCtrl = nCtrl; mCmd = nCmd; mBusy = nBusy; mTimeout = nTimeout; mDone = nDone;
    mRead = nRead; mBusyCycles = nCycles;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 32'h0, 1'b0);
    clockCycle();
    clockCycle();
    reset = 1'b0;
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_data_read: got %h expected %h", bus.readdata, 32'h0); end
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_status_read: got %h expected %h", bus.readdata, 32'h0); end
    nCompared++;
    if (outPort !== 10'h0) begin nMismatched++; $display("[TB] FAIL reset_out_port: got %h expected %h", outPort, 10'h0); end
    nCompared++;
    if (bus.cmd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid); end
  endtask

  task automatic test_data_write();
    drive(1'b1, 2'd0, 1'b0, 32'h155, 1'b0);
    clockCycle();
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 10'h155) begin
        nMismatched++;
        $display("[TB] FAIL data_cmd_hold[%0d]: got valid=%b data=%h expected valid=1 data=155", i, bus.cmd_valid, bus.cmd_data);
      end
      bus.cmd_ready = (i == 3);
      clockCycle();
    end
    nCompared++;
    if (bus.cmd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL data_cmd_drop: got %b expected 0", bus.cmd_valid); end
    nCompared++;
    if (outPort !== 10'h155) begin nMismatched++; $display("[TB] FAIL data_out_port: got %h expected 155", outPort); end
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0100) begin nMismatched++; $display("[TB] FAIL data_status: got %h expected 00000100", bus.readdata); end
  endtask

  task automatic test_set_clear();
    drive(1'b1, 2'd1, 1'b0, 32'h4, 1'b0);
    clockCycle();
    drive(1'b1, 2'd2, 1'b0, 32'h00A, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.cmd_data !== 10'h15F || outPort !== 10'h15F || bus.cmd_valid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL outset_cmd: got data=%h out=%h valid=%b expected 15F/15F/1", bus.cmd_data, outPort, bus.cmd_valid);
    end
    idle(1'b1);
    clockCycle();
    drive(1'b1, 2'd3, 1'b0, 32'h100, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.cmd_data !== 10'h05F || outPort !== 10'h05F) begin
      nMismatched++;
      $display("[TB] FAIL outclear_cmd: got data=%h out=%h expected 05F/05F", bus.cmd_data, outPort);
    end
    idle(1'b1);
    clockCycle();
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0200) begin nMismatched++; $display("[TB] FAIL setclear_done_cnt: got %h expected 00000200", bus.readdata); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd0, 1'b0, 32'h0AA, 1'b0);
    clockCycle();
    drive(1'b1, 2'd0, 1'b0, 32'h3FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clockCycle();
      nCompared++;
      if (sampWaitDut !== 1'b1 || outPort !== 10'h0AA) begin
        nMismatched++;
        $display("[TB] FAIL b2b_stall[%0d]: got wait=%b out=%h expected 1/0AA", i, sampWaitDut, outPort);
      end
    end
    bus.cmd_ready = 1'b1;
    clockCycle();
    nCompared++;
    if (sampWaitDut !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_accept_cycle: got wait=%b valid=%b expected 1/0", sampWaitDut, bus.cmd_valid);
    end
    bus.cmd_ready = 1'b0;
    clockCycle();
    nCompared++;
    if (sampWaitDut !== 1'b0 || outPort !== 10'h3FF || bus.cmd_valid !== 1'b1 || bus.cmd_data !== 10'h3FF) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second_cmd: got wait=%b out=%h valid=%b data=%h expected 0/3FF/1/3FF",
               sampWaitDut, outPort, bus.cmd_valid, bus.cmd_data);
    end
    drive(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (sampWaitDut !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_status_write_stall: got %b expected 0", sampWaitDut); end
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_status_busy: got %h expected bit0=1", bus.readdata); end
    idle(1'b1);
    clockCycle();
    idle(1'b0);
  endtask

  task automatic test_timeout();
    int seen;
    drive(1'b1, 2'd1, 1'b0, 32'h4, 1'b0);
    clockCycle();
    drive(1'b1, 2'd0, 1'b0, 32'h2A5, 1'b0);
    clockCycle();
    idle(1'b0);
    seen = 0;
    while (bus.cmd_valid === 1'b1 && seen < 30) begin
      seen++;
      clockCycle();
    end
`ifdef UART1_CTRL_TIMEOUT_EN
    nCompared++;
    if (seen !== TO) begin nMismatched++; $display("[TB] FAIL timeout_valid_cycles: got %0d expected %0d", seen, TO); end
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h2 || outPort !== 10'h2A5) begin
      nMismatched++;
      $display("[TB] FAIL timeout_status: got %h out=%h expected 00000002/2A5", bus.readdata, outPort);
    end
    drive(1'b1, 2'd1, 1'b0, 32'h2, 1'b0);
    clockCycle();
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL timeout_clear: got %h expected 00000000", bus.readdata); end
`else
    nCompared++;
    if (seen !== 30) begin nMismatched++; $display("[TB] FAIL no_timeout_wait: got %0d expected 30", seen); end
    drive(1'b1, 2'd1, 1'b0, 32'h2, 1'b0);
    clockCycle();
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h1) begin nMismatched++; $display("[TB] FAIL no_timeout_status: got %h expected 00000001", bus.readdata); end
    idle(1'b1);
    clockCycle();
    idle(1'b0);
`endif
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 2'd0, 1'b0, 32'h1C3, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.cmd_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstbusy_pre_valid: got %b expected 1", bus.cmd_valid); end
    reset = 1'b1;
    idle(1'b0);
    clockCycle();
    reset = 1'b0;
    nCompared++;
    if (bus.cmd_valid !== 1'b0 || outPort !== 10'h0 || bus.readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL rstbusy_drop: got valid=%b out=%h rd=%h expected 0/000/0", bus.cmd_valid, outPort, bus.readdata);
    end
    drive(1'b1, 2'd1, 1'b1, 32'h0, 1'b0);
    clockCycle();
    nCompared++;
    if (bus.readdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL rstbusy_status: got %h expected 00000000", bus.readdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) == 0);
      drive(1'($urandom_range(3) != 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
            $urandom, 1'($urandom_range(9) < 4));
      clockCycle();
      nCompared++;
      if (sampWaitDut !== sampWaitExp) begin nMismatched++; $display("[TB] FAIL rand_wait[%0d]: got %b expected %b", i, sampWaitDut, sampWaitExp); end
      nCompared++;
      if (bus.readdata !== mRead) begin nMismatched++; $display("[TB] FAIL rand_readdata[%0d]: got %h expected %h", i, bus.readdata, mRead); end
      nCompared++;
      if (outPort !== mCtrl) begin nMismatched++; $display("[TB] FAIL rand_out_port[%0d]: got %h expected %h", i, outPort, mCtrl); end
      nCompared++;
      if (bus.cmd_valid !== mBusy) begin nMismatched++; $display("[TB] FAIL rand_cmd_valid[%0d]: got %b expected %b", i, bus.cmd_valid, mBusy); end
      if (mBusy) begin
        nCompared++;
        if (bus.cmd_data !== mCmd) begin nMismatched++; $display("[TB] FAIL rand_cmd_data[%0d]: got %h expected %h", i, bus.cmd_data, mCmd); end
      end
    end
    reset = 1'b0;
    idle(1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(1'b0);
    test_reset();
    test_data_write();
    test_set_clear();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
